ctrl_pipe_dec: RTL and testbench

- Parametrised successor to the single-cycle MIPS main decoder.
- Decodes the ID-stage opcode and carries the control word through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Each stage's consumers receive registered, stage-aligned control signals.
- Adds optional extended opcodes, illegal-opcode detection, stall/flush bubble insertion and a saturating bubble counter for the hazard unit.

---
 rtl/ctrl_pipe_dec.sv | 160 ++++++++++++++++
 tb/tb_ctrl_pipe_dec.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_dec.sv
// rtl/ctrl_pipe_dec.sv - pipelined MIPS main decoder with illegal detect, bubble insertion and bubble counter
// Control word is decoded in ID and carried through ID/EX, EX/MEM and MEM/WB registers.
module ctrl_pipe_dec #(
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 16,
  localparam int ALUOP_W = (EXT_OPS != 0) ? 3 : 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         id_op,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               flush,
  output logic               id_jump,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_valid,
  output logic               ex_illegal,
  output logic               mem_branch,
  output logic               mem_mem_write,
  output logic               mem_valid,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_valid,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam bit EXT = (EXT_OPS != 0);

  logic       dec_reg_write, dec_reg_dst, dec_alu_src, dec_branch;
  logic       dec_mem_write, dec_mem_to_reg, dec_illegal, dec_jump;
  logic [2:0] dec_alu_op;
  logic       load_bubble;

  // EX-stage copies of the controls consumed further down the pipe
  logic ex_branch, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic mem_reg_write, mem_mem_to_reg;

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_op     = 3'b000;
    dec_illegal    = 1'b0;
    dec_jump       = 1'b0;
    case (id_op)
      OP_R: begin
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
        dec_alu_op    = 3'b010;
      end
      OP_LW: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu_op = 3'b001;
      end
      OP_ADDI: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EXT) begin
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_alu_op    = (id_op == OP_ANDI) ? 3'b011 :
                          (id_op == OP_ORI)  ? 3'b100 : 3'b101;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_J: begin
        if (EXT) dec_jump = 1'b1;
        else     dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign id_jump     = id_valid & dec_jump;
  assign load_bubble = flush | stall | ~id_valid;

  always_ff @(posedge clk) begin
    if (reset || load_bubble) begin
      ex_reg_write  <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_op     <= '0;
      ex_valid      <= 1'b0;
      ex_illegal    <= 1'b0;
    end else begin
      ex_reg_write  <= dec_reg_write;
      ex_reg_dst    <= dec_reg_dst;
      ex_alu_src    <= dec_alu_src;
      ex_branch     <= dec_branch;
      ex_mem_write  <= dec_mem_write;
      ex_mem_to_reg <= dec_mem_to_reg;
      ex_alu_op     <= dec_alu_op[ALUOP_W-1:0];
      ex_valid      <= 1'b1;
      ex_illegal    <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_branch     <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_valid      <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_valid       <= 1'b0;
    end else begin
      mem_branch     <= ex_branch;
      mem_mem_write  <= ex_mem_write;
      mem_reg_write  <= ex_reg_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_valid      <= ex_valid;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_valid       <= mem_valid;
    end
  end

  // Only hazard-driven bubbles count; an empty ID slot is not a hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if ((stall || flush) && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_dec.sv
// tb/tb_ctrl_pipe_dec.sv - scoreboard bench for ctrl_pipe_dec in extended and base modes
module tb_ctrl_pipe_dec;

  typedef struct packed {
    logic       rw, rd, as, br, mw, mr;
    logic [2:0] op;
    logic       v, il;
  } exp_t;

  typedef struct packed {
    exp_t e1;
    exp_t e0;
    logic rst;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] id_op = 6'h00;
  logic       id_valid = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic       d1_id_jump, d1_ex_reg_dst, d1_ex_alu_src, d1_ex_valid, d1_ex_illegal;
  logic [2:0] d1_ex_alu_op;
  logic       d1_mem_branch, d1_mem_mem_write, d1_mem_valid;
  logic       d1_wb_reg_write, d1_wb_mem_to_reg, d1_wb_valid;
  logic [3:0] d1_bubble_cnt;

  logic        d0_id_jump, d0_ex_reg_dst, d0_ex_alu_src, d0_ex_valid, d0_ex_illegal;
  logic [1:0]  d0_ex_alu_op;
  logic        d0_mem_branch, d0_mem_mem_write, d0_mem_valid;
  logic        d0_wb_reg_write, d0_wb_mem_to_reg, d0_wb_valid;
  logic [15:0] d0_bubble_cnt;

  int checks = 0;
  int errors = 0;
  ent_t exq[$];
  exp_t mp1, mp0, wp1, wp0;
  int cnt1 = 0;
  int cnt0 = 0;

  always #5 clk = ~clk;

  ctrl_pipe_dec #(.EXT_OPS(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .id_op(id_op), .id_valid(id_valid),
    .stall(stall), .flush(flush), .id_jump(d1_id_jump),
    .ex_reg_dst(d1_ex_reg_dst), .ex_alu_src(d1_ex_alu_src), .ex_alu_op(d1_ex_alu_op),
    .ex_valid(d1_ex_valid), .ex_illegal(d1_ex_illegal),
    .mem_branch(d1_mem_branch), .mem_mem_write(d1_mem_mem_write), .mem_valid(d1_mem_valid),
    .wb_reg_write(d1_wb_reg_write), .wb_mem_to_reg(d1_wb_mem_to_reg), .wb_valid(d1_wb_valid),
    .bubble_cnt(d1_bubble_cnt)
  );

  ctrl_pipe_dec #(.EXT_OPS(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_op(id_op), .id_valid(id_valid),
    .stall(stall), .flush(flush), .id_jump(d0_id_jump),
    .ex_reg_dst(d0_ex_reg_dst), .ex_alu_src(d0_ex_alu_src), .ex_alu_op(d0_ex_alu_op),
    .ex_valid(d0_ex_valid), .ex_illegal(d0_ex_illegal),
    .mem_branch(d0_mem_branch), .mem_mem_write(d0_mem_mem_write), .mem_valid(d0_mem_valid),
    .wb_reg_write(d0_wb_reg_write), .wb_mem_to_reg(d0_wb_mem_to_reg), .wb_valid(d0_wb_valid),
    .bubble_cnt(d0_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode table: {rw,rd,as,br,mw,mr,aluop,valid,illegal}
  function automatic exp_t ref_dec(input bit ext, input logic [5:0] op,
                                   input bit v, input bit st, input bit fl);
    exp_t e;
    e = '0;
    if (fl || st || !v) return e;
    e.v = 1'b1;
    case (op)
      6'h00: begin e.rw = 1; e.rd = 1; e.op = 3'b010; end
      6'h23: begin e.rw = 1; e.as = 1; e.mr = 1; end
      6'h2B: begin e.as = 1; e.mw = 1; end
      6'h04: begin e.br = 1; e.op = 3'b001; end
      6'h08: begin e.rw = 1; e.as = 1; end
      6'h0C: if (ext) begin e.rw = 1; e.as = 1; e.op = 3'b011; end else e.il = 1;
      6'h0D: if (ext) begin e.rw = 1; e.as = 1; e.op = 3'b100; end else e.il = 1;
      6'h0A: if (ext) begin e.rw = 1; e.as = 1; e.op = 3'b101; end else e.il = 1;
      6'h02: if (!ext) e.il = 1;
      default: e.il = 1;
    endcase
    return e;
  endfunction

  task automatic step(input bit r, input logic [5:0] op, input bit v,
                      input bit st, input bit fl);
    ent_t ent;
    @(negedge clk);
    reset = r; id_op = op; id_valid = v; stall = st; flush = fl;
    #1;
    check("jump1", 32'(d1_id_jump), 32'(v && (op == 6'h02)));
    check("jump0", 32'(d0_id_jump), 32'd0);
    ent.rst = r;
    ent.e1  = r ? '0 : ref_dec(1'b1, op, v, st, fl);
    ent.e0  = r ? '0 : ref_dec(1'b0, op, v, st, fl);
    exq.push_back(ent);
    @(posedge clk);
    #1;
    if (r) cnt1 = 0; else if ((st || fl) && cnt1 < 15) cnt1++;
    if (r) cnt0 = 0; else if ((st || fl) && cnt0 < 65535) cnt0++;
    check("cnt1", 32'(d1_bubble_cnt), 32'(cnt1));
    check("cnt0", 32'(d0_bubble_cnt), 32'(cnt0));
    if (exq.size() == 0) begin
      check("queue_empty", 32'(exq.size()), 32'd1);
    end else begin
      ent = exq.pop_front();
      if (ent.rst) begin mp1 = '0; mp0 = '0; wp1 = '0; wp0 = '0; end
      check("wb1", 32'({d1_wb_reg_write, d1_wb_mem_to_reg, d1_wb_valid}),
            32'({wp1.rw, wp1.mr, wp1.v}));
      check("wb0", 32'({d0_wb_reg_write, d0_wb_mem_to_reg, d0_wb_valid}),
            32'({wp0.rw, wp0.mr, wp0.v}));
      check("mem1", 32'({d1_mem_branch, d1_mem_mem_write, d1_mem_valid}),
            32'({mp1.br, mp1.mw, mp1.v}));
      check("mem0", 32'({d0_mem_branch, d0_mem_mem_write, d0_mem_valid}),
            32'({mp0.br, mp0.mw, mp0.v}));
      check("ex1", 32'({d1_ex_reg_dst, d1_ex_alu_src, d1_ex_alu_op, d1_ex_valid, d1_ex_illegal}),
            32'({ent.e1.rd, ent.e1.as, ent.e1.op, ent.e1.v, ent.e1.il}));
      check("ex0", 32'({d0_ex_reg_dst, d0_ex_alu_src, d0_ex_alu_op, d0_ex_valid, d0_ex_illegal}),
            32'({ent.e0.rd, ent.e0.as, ent.e0.op[1:0], ent.e0.v, ent.e0.il}));
      wp1 = mp1; wp0 = mp0;
      mp1 = ent.e1; mp0 = ent.e0;
    end
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h3F};
    mp1 = '0; mp0 = '0; wp1 = '0; wp0 = '0;

    step(1, 6'h23, 1, 0, 0);
    step(1, 6'h23, 1, 0, 0);
    step(0, 6'h23, 1, 0, 0);
    // back-to-back lw, sw, beq, R, addi
    step(0, 6'h23, 1, 0, 0);
    step(0, 6'h2B, 1, 0, 0);
    step(0, 6'h04, 1, 0, 0);
    step(0, 6'h00, 1, 0, 0);
    step(0, 6'h08, 1, 0, 0);
    // load-use stall: add held in ID for one extra cycle
    step(0, 6'h23, 1, 0, 0);
    step(0, 6'h00, 1, 1, 0);
    step(0, 6'h00, 1, 0, 0);
    // flush and stall together on beq
    step(0, 6'h04, 1, 1, 1);
    step(0, 6'h08, 1, 0, 0);
    // illegal and extended opcodes
    step(0, 6'h3F, 1, 0, 0);
    step(0, 6'h0C, 1, 0, 0);
    step(0, 6'h0D, 1, 0, 0);
    step(0, 6'h0A, 1, 0, 0);
    step(0, 6'h02, 1, 0, 0);
    step(0, 6'h02, 1, 1, 1);
    step(0, 6'h02, 0, 0, 0);
    step(0, 6'h23, 0, 0, 0);
    step(0, 6'h00, 0, 0, 0);
    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 6'h23, 1, 1, 0);
    step(0, 6'h2B, 1, 0, 0);
    // reset mid-flight
    step(0, 6'h23, 1, 0, 0);
    step(1, 6'h2B, 1, 0, 0);
    step(0, 6'h00, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      step(($urandom_range(0, 29) == 0), op, ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    end
    for (int i = 0; i < 4; i++) step(0, 6'h00, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
